// File: rtl/logic_wave_renderer.sv
// logic_wave_renderer
//   Captures NUM_CH probe channels into a NUM_COLS-deep sample buffer using an
//   armed, rising-edge-triggered capture FSM. It also renders that buffer as
//   square-wave traces, one 64-row horizontal band per channel, by addressing an
//   external 8x64 tile ROM that has a one-cycle registered read.
//
//   Optional build macro: FORCE_TRIG_EN adds the force_trig input. In ARMED,
//   sample_tick & force_trig then starts a capture exactly as a trigger edge does.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   probe               channels under test (clk domain)
//   sample_tick         one-cycle sample strobe
//   arm                 pulse: restart capture (waits for trigger)
//   trig_sel            channel whose rising edge starts the capture
//   force_trig          (FORCE_TRIG_EN only) trigger without an edge
//   pixel_x/pixel_y     raster coordinates, with video_on for the visible area
//   rom_addr            {prev_sample, cur_sample, row[5:0]} to the tile ROM
//   rom_data            ROM word for the previous cycle's rom_addr
//   wave_pixel          trace pixel, 3 clocks after its pixel_x/pixel_y
//   wave_band           pixel lies inside a channel band (same timing)
//   cap_state           IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   cap_done            high while cap_state is DONE
module logic_wave_renderer #(
    parameter int NUM_CH     = 4,
    parameter int NUM_COLS   = 80,
    parameter int Y_TOP      = 64,
    parameter int BAND_PITCH = 96
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         probe,
    input  logic                      sample_tick,
    input  logic                      arm,
    input  logic [$clog2(NUM_CH)-1:0] trig_sel,
`ifdef FORCE_TRIG_EN
    input  logic                      force_trig,
`endif
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic                      video_on,
    output logic [7:0]                rom_addr,
    input  logic [7:0]                rom_data,
    output logic                      wave_pixel,
    output logic                      wave_band,
    output logic [1:0]                cap_state,
    output logic                      cap_done
);

    localparam int CW  = $clog2(NUM_COLS);
    localparam int CHW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   wr_idx_q, wr_idx_d;
    logic [NUM_CH-1:0]               prev_probe_q, prev_probe_d;
    logic [NUM_COLS-1:0][NUM_CH-1:0] buf_q, buf_d;
    logic                            cap_done_q, cap_done_d;
    logic                            trig;

    // Render pipeline: stage 1 (ROM address + bit index), stage 2 (aligned with rom_data)
    logic       prev_s1_q, prev_s1_d, cur_s1_q, cur_s1_d, inb_s1_q, inb_s1_d;
    logic [5:0] row_s1_q, row_s1_d;
    logic [2:0] bit_s1_q, bit_s1_d, bit_s2_q;
    logic       inb_s2_q;
    logic       wave_pixel_q, wave_pixel_d, wave_band_q;

    // Decode of the current raster coordinate
    logic           hit, col_ok, in_band, cur_smp, prev_smp;
    logic [CHW-1:0] ch;
    logic [5:0]     row;
    logic [6:0]     col, ci, pi;

    // ---------------- capture ----------------
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        buf_d        = buf_q;
        prev_probe_d = sample_tick ? probe : prev_probe_q;
        trig         = 1'b0;
        // out-of-range channel selects never trigger
        if (int'(trig_sel) < NUM_CH)
            trig = sample_tick & probe[trig_sel] & ~prev_probe_q[trig_sel];
`ifdef FORCE_TRIG_EN
        trig = trig | (sample_tick & force_trig);
`endif
        if (arm) begin
            // arm wins over a same-cycle trigger or sample write; buffer is kept
            state_d  = ARMED;
            wr_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: if (trig) begin
                    buf_d[0] = probe;
                    wr_idx_d = CW'(1);
                    state_d  = CAPTURE;
                end
                CAPTURE: if (sample_tick) begin
                    buf_d[wr_idx_q] = probe;
                    wr_idx_d        = wr_idx_q + 1'b1;
                    if (wr_idx_q == CW'(NUM_COLS - 1)) state_d = DONE;
                end
                default: ;  // DONE: buffer frozen until the next arm
            endcase
        end
        cap_done_d = (state_d == DONE);
    end

    // ---------------- render decode ----------------
    always_comb begin
        hit = 1'b0;
        ch  = '0;
        row = '0;
        // bands never overlap (BAND_PITCH >= 64), so at most one matches
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(pixel_y) >= Y_TOP + c * BAND_PITCH &&
                int'(pixel_y) <  Y_TOP + c * BAND_PITCH + 64) begin
                hit = 1'b1;
                ch  = CHW'(c);
                row = 6'(int'(pixel_y) - (Y_TOP + c * BAND_PITCH));
            end
        end
        col      = pixel_x[9:3];
        col_ok   = int'(col) < NUM_COLS;
        ci       = col_ok ? col : 7'd0;
        pi       = (ci == 7'd0) ? ci : ci - 7'd1;  // column 0 has no left neighbour
        in_band  = video_on & hit & col_ok;
        cur_smp  = buf_q[ci][ch];
        prev_smp = buf_q[pi][ch];

        // outside a band the ROM address is forced to 8'h00
        prev_s1_d = in_band & prev_smp;
        cur_s1_d  = in_band & cur_smp;
        row_s1_d  = in_band ? row : 6'd0;
        bit_s1_d  = pixel_x[2:0];
        inb_s1_d  = in_band;

        wave_pixel_d = inb_s2_q & rom_data[3'd7 - bit_s2_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            prev_probe_q <= '0;
            buf_q        <= '0;
            cap_done_q   <= 1'b0;
            prev_s1_q    <= 1'b0;
            cur_s1_q     <= 1'b0;
            row_s1_q     <= '0;
            bit_s1_q     <= '0;
            inb_s1_q     <= 1'b0;
            bit_s2_q     <= '0;
            inb_s2_q     <= 1'b0;
            wave_pixel_q <= 1'b0;
            wave_band_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            prev_probe_q <= prev_probe_d;
            buf_q        <= buf_d;
            cap_done_q   <= cap_done_d;
            prev_s1_q    <= prev_s1_d;
            cur_s1_q     <= cur_s1_d;
            row_s1_q     <= row_s1_d;
            bit_s1_q     <= bit_s1_d;
            inb_s1_q     <= inb_s1_d;
            bit_s2_q     <= bit_s1_q;
            inb_s2_q     <= inb_s1_q;
            wave_pixel_q <= wave_pixel_d;
            wave_band_q  <= inb_s2_q;
        end
    end

    assign rom_addr   = {prev_s1_q, cur_s1_q, row_s1_q};
    assign wave_pixel = wave_pixel_q;
    assign wave_band  = wave_band_q;
    assign cap_state  = state_q;
    assign cap_done   = cap_done_q;

endmodule

// File: tb/tb_logic_wave_renderer.sv
// Directed bench for logic_wave_renderer: capture FSM, reset, rendering through
// a behavioural square-wave tile ROM with a one-cycle registered read.
module tb_logic_wave_renderer;

    localparam int NUM_CH = 4, NUM_COLS = 80, Y_TOP = 64, BAND_PITCH = 96;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] probe;
    logic       sample_tick, arm;
    logic [1:0] trig_sel;
`ifdef FORCE_TRIG_EN
    logic       force_trig;
`endif
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic [7:0] rom_addr, rom_data;
    logic       wave_pixel, wave_band;
    logic [1:0] cap_state;
    logic       cap_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ra;
    logic       wp, wb;

    logic_wave_renderer #(
        .NUM_CH(NUM_CH), .NUM_COLS(NUM_COLS), .Y_TOP(Y_TOP), .BAND_PITCH(BAND_PITCH)
    ) dut (
        .clk(clk), .rst(rst), .probe(probe), .sample_tick(sample_tick), .arm(arm),
        .trig_sel(trig_sel),
`ifdef FORCE_TRIG_EN
        .force_trig(force_trig),
`endif
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .rom_addr(rom_addr), .rom_data(rom_data), .wave_pixel(wave_pixel),
        .wave_band(wave_band), .cap_state(cap_state), .cap_done(cap_done)
    );

    always #5 clk = ~clk;

    // Square-wave tile: top row draws the high level, bottom row the low level,
    // a transition (prev != cur) switches level at pixel 4 with a vertical line.
    function automatic logic [7:0] rom_model(input logic [7:0] a);
        logic p, c;
        p = a[7];
        c = a[6];
        if (a[5:0] == 6'd0)  return {{4{p}}, {4{c}}};
        if (a[5:0] == 6'd63) return {{4{~p}}, {4{~c}}};
        return (p != c) ? 8'h08 : 8'h00;
    endfunction

    always @(posedge clk) rom_data <= rom_model(rom_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tick(input logic [3:0] p);
        probe = p;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // One pixel for one cycle, then park off-screen so latency errors show up.
    task automatic render(input int x, input int y, input logic von,
                          output logic [7:0] a, output logic p, output logic b);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        video_on = von;
        step();
        a = rom_addr;
        video_on = 1'b0;
        pixel_y = 10'd0;
        step();
        step();
        p = wave_pixel;
        b = wave_band;
    endtask

    task automatic test_reset();
        rst = 1'b1; probe = '0; sample_tick = 0; arm = 0; trig_sel = 2'd1;
`ifdef FORCE_TRIG_EN
        force_trig = 1'b0;
`endif
        pixel_x = '0; pixel_y = '0; video_on = 0;
        step(); step();
        checks++; if (cap_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", cap_state); end
        checks++; if ({cap_done, wave_pixel, wave_band, rom_addr} !== 11'd0) begin errors++;
            $display("FAIL reset_outputs got done=%0b wp=%0b wb=%0b addr=%h exp all 0", cap_done, wave_pixel, wave_band, rom_addr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_capture();
        trig_sel = 2'd1;
        pulse_arm();
        send_tick(4'h0);
        send_tick(4'hF);                       // edge: buf[0], wr_idx=1
        for (int k = 1; k < 40; k++) send_tick(4'hF);  // wr_idx=40
        checks++; if (cap_state !== 2'd2) begin errors++; $display("FAIL midcap_state got %0d exp 2", cap_state); end
        rst = 1'b1;
        step();
        checks++; if ({cap_state, cap_done, wave_pixel, rom_addr} !== 12'd0) begin errors++;
            $display("FAIL midcap_reset got st=%0d done=%0b wp=%0b addr=%h exp all 0", cap_state, cap_done, wave_pixel, rom_addr); end
        rst = 1'b0;
        step();
        render(40, Y_TOP + 2*BAND_PITCH + 10, 1'b1, ra, wp, wb);
        checks++; if (ra !== 8'h0A || wb !== 1'b1 || wp !== 1'b0) begin errors++;
            $display("FAIL midcap_buf_clear_b2 got addr=%h wb=%0b wp=%0b exp 0a 1 0", ra, wb, wp); end
        render(40, Y_TOP, 1'b1, ra, wp, wb);
        checks++; if (ra !== 8'h00 || wp !== 1'b0) begin errors++;
            $display("FAIL midcap_buf_clear_b0 got addr=%h wp=%0b exp 00 0", ra, wp); end
    endtask

    task automatic test_capture();
        logic [6:0] k7;
        trig_sel = 2'd1;
        pulse_arm();
        checks++; if (cap_state !== 2'd1) begin errors++; $display("FAIL cap_armed got %0d exp 1", cap_state); end
        send_tick(4'b0100);
        send_tick(4'b0100);
        checks++; if (cap_state !== 2'd1) begin errors++; $display("FAIL cap_no_edge got %0d exp 1", cap_state); end
        send_tick(4'b0110);                    // third tick: ch1 rises, k=0
        checks++; if (cap_state !== 2'd2) begin errors++; $display("FAIL cap_trigger got %0d exp 2", cap_state); end
        for (int k = 1; k < NUM_COLS; k++) begin
            k7 = 7'(k);
            send_tick({k7[0], 1'b1, 1'b1, (k >= 5)});
            if (k == NUM_COLS - 2) begin
                checks++; if (cap_state !== 2'd2 || cap_done !== 1'b0) begin errors++;
                    $display("FAIL cap_before_last got st=%0d done=%0b exp 2 0", cap_state, cap_done); end
            end
        end
        checks++; if (cap_state !== 2'd3 || cap_done !== 1'b1) begin errors++;
            $display("FAIL cap_done got st=%0d done=%0b exp 3 1", cap_state, cap_done); end
        send_tick(4'h0);                       // DONE ignores further samples
        checks++; if (cap_state !== 2'd3) begin errors++; $display("FAIL cap_hold got %0d exp 3", cap_state); end
        render(0, Y_TOP + BAND_PITCH, 1'b1, ra, wp, wb);  // buf[0][1]=1, col 0 prev=cur
        checks++; if (ra !== 8'hC0 || wp !== 1'b1) begin errors++;
            $display("FAIL cap_buf0_ch1 got addr=%h wp=%0b exp c0 1", ra, wp); end
    endtask

    task automatic test_render_transition();
        // x=40..47 streamed back to back: col 5, ch0 prev=0 cur=1, row 0
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                pixel_x = 10'(40 + i); pixel_y = 10'(Y_TOP); video_on = 1'b1;
            end else begin
                video_on = 1'b0; pixel_y = 10'd0;
            end
            step();
            if (i < 8) begin
                checks++; if (rom_addr !== 8'h40) begin errors++;
                    $display("FAIL trans_addr px%0d got %h exp 40", i, rom_addr); end
            end
            if (i >= 2 && i < 10) begin
                checks++; if (wave_pixel !== (i - 2 >= 4)) begin errors++;
                    $display("FAIL trans_wp px%0d got %0b exp %0b", i - 2, wave_pixel, (i - 2 >= 4)); end
            end
        end
    endtask

    task automatic test_render_level();
        render(100, Y_TOP + 2*BAND_PITCH + 10, 1'b1, ra, wp, wb);
        checks++; if (ra !== 8'hCA || wp !== 1'b0 || wb !== 1'b1) begin errors++;
            $display("FAIL level_row10 got addr=%h wp=%0b wb=%0b exp ca 0 1", ra, wp, wb); end
        render(100, Y_TOP + 2*BAND_PITCH, 1'b1, ra, wp, wb);
        checks++; if (ra !== 8'hC0 || wp !== 1'b1) begin errors++;
            $display("FAIL level_row0 got addr=%h wp=%0b exp c0 1", ra, wp); end
        render(639, Y_TOP + 3*BAND_PITCH, 1'b1, ra, wp, wb);  // last col, ch3 rising
        checks++; if (ra !== 8'h40 || wp !== 1'b1 || wb !== 1'b1) begin errors++;
            $display("FAIL level_lastcol got addr=%h wp=%0b wb=%0b exp 40 1 1", ra, wp, wb); end
        render(632, Y_TOP + 3*BAND_PITCH, 1'b1, ra, wp, wb);
        checks++; if (wp !== 1'b0) begin errors++; $display("FAIL level_lastcol_bit0 got %0b exp 0", wp); end
        render(40, Y_TOP + 63, 1'b1, ra, wp, wb);             // band 0 bottom row
        checks++; if (ra !== 8'h7F || wp !== 1'b1 || wb !== 1'b1) begin errors++;
            $display("FAIL level_row63 got addr=%h wp=%0b wb=%0b exp 7f 1 1", ra, wp, wb); end
    endtask

    task automatic test_render_outside();
        render(100, Y_TOP + 70, 1'b1, ra, wp, wb);
        checks++; if (ra !== 8'h00 || wp !== 1'b0 || wb !== 1'b0) begin errors++;
            $display("FAIL out_gap got addr=%h wp=%0b wb=%0b exp 00 0 0", ra, wp, wb); end
        render(Y_TOP + 0 + 584, Y_TOP, 1'b1, ra, wp, wb);    // x=648
        checks++; if (ra !== 8'h00 || wp !== 1'b0 || wb !== 1'b0) begin errors++;
            $display("FAIL out_x648 got addr=%h wp=%0b wb=%0b exp 00 0 0", ra, wp, wb); end
        render(640, Y_TOP, 1'b1, ra, wp, wb);
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL out_x640 got wb=%0b exp 0", wb); end
        render(44, Y_TOP, 1'b0, ra, wp, wb);
        checks++; if (ra !== 8'h00 || wp !== 1'b0 || wb !== 1'b0) begin errors++;
            $display("FAIL out_video_off got addr=%h wp=%0b wb=%0b exp 00 0 0", ra, wp, wb); end
        render(44, Y_TOP + 64, 1'b1, ra, wp, wb);
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL out_row64 got wb=%0b exp 0", wb); end
    endtask

    task automatic test_arm_priority();
        trig_sel = 2'd1;
        pulse_arm();                           // DONE -> ARMED, prev_probe[1]=0
        probe = 4'b0010; sample_tick = 1'b1; arm = 1'b1;
        step();
        sample_tick = 1'b0; arm = 1'b0;
        step();
        checks++; if (cap_state !== 2'd1) begin errors++; $display("FAIL arm_vs_edge got %0d exp 1", cap_state); end
        send_tick(4'b0000);
        send_tick(4'b0010);                    // edge -> CAPTURE
        for (int k = 0; k < 10; k++) send_tick(4'b0010);
        pulse_arm();                           // mid-capture rearm
        checks++; if (cap_state !== 2'd1) begin errors++; $display("FAIL arm_midcap got %0d exp 1", cap_state); end
        send_tick(4'b0000);
        send_tick(4'b0010);
        for (int k = 1; k < NUM_COLS - 1; k++) send_tick(4'b0010);
        checks++; if (cap_state !== 2'd2) begin errors++; $display("FAIL arm_widx_reset got %0d exp 2", cap_state); end
        send_tick(4'b0010);
        checks++; if (cap_state !== 2'd3) begin errors++; $display("FAIL arm_recap_done got %0d exp 3", cap_state); end
    endtask

`ifdef FORCE_TRIG_EN
    task automatic test_force_trig();
        trig_sel = 2'd1;
        pulse_arm();
        force_trig = 1'b1;
        send_tick(4'b0000);
        force_trig = 1'b0;
        checks++; if (cap_state !== 2'd2) begin errors++; $display("FAIL force_trig got %0d exp 2", cap_state); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_capture();
        test_capture();
        test_render_transition();
        test_render_level();
        test_render_outside();
        test_arm_priority();
`ifdef FORCE_TRIG_EN
        test_force_trig();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
